// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined slave over an internal word-addressed RAM.
// Fixed ack latency, bounded outstanding requests, abort on cyc drop.
module wb_mem_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        mem_q [DEPTH];
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];
  logic [CW-1:0]      count_q, count_d;

  logic               accept_c;
  logic               ack_c;
  logic               in_range_c;
  logic [AW-1:0]      idx_c;
  logic [31:0]        rd_word_c;
  logic               unused_adr_c;

  assign unused_adr_c = &{1'b0, wb_adr_i[1:0]};

  // Stall comes only from the registered count, so it has no input path.
  assign wb_stall_o = (count_q == CW'(MAX_OUTSTANDING));
  assign accept_c   = wb_stb_i & wb_cyc_i & ~wb_stall_o & rst_i;
  assign idx_c      = wb_adr_i[AW+1:2];
  assign in_range_c = (wb_adr_i[31:AW+2] == '0);
  assign rd_word_c  = in_range_c ? mem_q[idx_c] : 32'h0;

  assign ack_c    = valid_q[LATENCY-1] & wb_cyc_i;
  assign wb_ack_o = ack_c;
  assign wb_dat_o = ack_c ? data_q[LATENCY-1] : 32'h0;

  // Pipeline shift and outstanding count; a cyc drop clears both.
  always_comb begin
    valid_d   = '0;
    data_d[0] = wb_we_i ? 32'h0 : rd_word_c;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      data_d[i] = data_q[i-1];
    end
    if (wb_cyc_i) begin
      valid_d[0] = accept_c;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end

    count_d = count_q;
    if (!wb_cyc_i) begin
      count_d = '0;
    end else if (accept_c && !ack_c) begin
      count_d = count_q + CW'(1);
    end else if (!accept_c && ack_c) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Memory is not reset so its contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (accept_c && wb_we_i && in_range_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem_q[idx_c][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder at DEPTH=1024, LATENCY=2, MAX_OUTSTANDING=2.
module tb_wb_mem_responder;

  localparam int LATENCY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_stall_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_mem_responder #(
    .DEPTH(1024), .LATENCY(LATENCY), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o)
  );

  // Single transaction; lat = edges from accept to visible ack, -1 on timeout.
  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    int k = 0;
    rdat = 32'h0;
    lat  = -1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    #1;
    while (wb_stall_o && k < 16) begin
      @(posedge clk_i); #1; k++;
    end
    if (wb_stall_o) begin
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    k = 1;
    while (!wb_ack_o && k < 16) begin
      @(posedge clk_i); #1; k++;
    end
    if (wb_ack_o) begin
      lat  = k;
      rdat = wb_dat_o;
    end
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'h0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", wb_stall_o); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] r;
    int lat;
    bus_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, lat);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL single_wr_lat: got %0d expected %0d", lat, LATENCY); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL single_wr_dat: got %h expected 0", r); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, r, lat);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL single_rd_lat: got %0d expected %0d", lat, LATENCY); end
    checks++; if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rd_dat: got %h expected deadbeef", r); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] r;
    int lat;
    bus_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, r, lat);
    bus_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, r, lat);
    bus_xfer(1'b0, 32'h20, 32'h0, 4'h0, r, lat);
    checks++; if (r !== 32'h11BB33DD) begin failures++; $display("FAIL byte_en: got %h expected 11bb33dd", r); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r;
    int lat;
    bus_xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r, lat);
    bus_xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, r, lat);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL oor_wr_ack: got lat %0d expected %0d", lat, LATENCY); end
    bus_xfer(1'b0, 32'h1000, 32'h0, 4'hF, r, lat);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL oor_rd_ack: got lat %0d expected %0d", lat, LATENCY); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL oor_rd_dat: got %h expected 0", r); end
    bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_alias: got %h expected cafef00d", r); end
  endtask

  task automatic test_burst();
    logic [31:0] d [4] = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003, 32'hD0D00004};
    logic        stb_t [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int          ai    [8] = '{0, 1, 1, 2, 3, 3, 3, 3};
    logic        st_t  [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int          di    [8] = '{-1, -1, 0, 1, -1, 2, 3, -1};
    logic [31:0] r, exp_dat;
    logic        exp_ack;
    int lat;
    int acks = 0;
    for (int i = 0; i < 4; i++) bus_xfer(1'b1, 32'h40 + 32'(4 * i), d[i], 4'hF, r, lat);
    wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      wb_stb_i = stb_t[i];
      wb_adr_i = 32'h40 + 32'(4 * ai[i]);
      #1;
      exp_ack = (di[i] >= 0);
      exp_dat = 32'h0;
      if (di[i] >= 0) exp_dat = d[di[i]];
      checks++; if (wb_stall_o !== st_t[i]) begin failures++; $display("FAIL burst_stall c%0d: got %b expected %b", i, wb_stall_o, st_t[i]); end
      checks++; if (wb_ack_o !== exp_ack) begin failures++; $display("FAIL burst_ack c%0d: got %b expected %b", i, wb_ack_o, exp_ack); end
      checks++; if (wb_dat_o !== exp_dat) begin failures++; $display("FAIL burst_dat c%0d: got %h expected %h", i, wb_dat_o, exp_dat); end
      if (wb_ack_o === 1'b1) acks++;
      @(posedge clk_i); #1;
    end
    checks++; if (acks !== 4) begin failures++; $display("FAIL burst_ack_count: got %0d expected 4", acks); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_read_after_write();
    logic        stb_t [4] = '{1, 1, 0, 0};
    logic        we_t  [4] = '{1, 0, 0, 0};
    logic        st_t  [4] = '{0, 0, 1, 0};
    logic        ak_t  [4] = '{0, 0, 1, 1};
    logic [31:0] dt_t  [4] = '{32'h0, 32'h0, 32'h0, 32'h5A5A1234};
    wb_cyc_i = 1'b1; wb_adr_i = 32'h80; wb_dat_i = 32'h5A5A1234; wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wb_stb_i = stb_t[i]; wb_we_i = we_t[i];
      #1;
      checks++; if (wb_stall_o !== st_t[i]) begin failures++; $display("FAIL raw_stall c%0d: got %b expected %b", i, wb_stall_o, st_t[i]); end
      checks++; if (wb_ack_o !== ak_t[i]) begin failures++; $display("FAIL raw_ack c%0d: got %b expected %b", i, wb_ack_o, ak_t[i]); end
      checks++; if (wb_dat_o !== dt_t[i]) begin failures++; $display("FAIL raw_dat c%0d: got %h expected %h", i, wb_dat_o, dt_t[i]); end
      @(posedge clk_i); #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_abort();
    logic        cyc_t [7] = '{1, 1, 0, 1, 1, 1, 1};
    logic        stb_t [7] = '{1, 1, 0, 1, 1, 0, 0};
    logic [31:0] adr_t [7] = '{32'h10, 32'h20, 32'h0, 32'h40, 32'h20, 32'h0, 32'h0};
    logic        st_t  [7] = '{0, 0, 1, 0, 0, 1, 0};
    logic        ak_t  [7] = '{0, 0, 0, 0, 0, 1, 1};
    logic [31:0] dt_t  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA0A00001, 32'h11BB33DD};
    wb_we_i = 1'b0; wb_sel_i = 4'hF;
    for (int i = 0; i < 7; i++) begin
      wb_cyc_i = cyc_t[i]; wb_stb_i = stb_t[i]; wb_adr_i = adr_t[i];
      #1;
      checks++; if (wb_stall_o !== st_t[i]) begin failures++; $display("FAIL abort_stall c%0d: got %b expected %b", i, wb_stall_o, st_t[i]); end
      checks++; if (wb_ack_o !== ak_t[i]) begin failures++; $display("FAIL abort_ack c%0d: got %b expected %b", i, wb_ack_o, ak_t[i]); end
      checks++; if (wb_dat_o !== dt_t[i]) begin failures++; $display("FAIL abort_dat c%0d: got %h expected %h", i, wb_dat_o, dt_t[i]); end
      @(posedge clk_i); #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] r;
    int lat;
    bus_xfer(1'b1, 32'h100, 32'h600DF00D, 4'hF, r, lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_adr_i = 32'h100;
    @(posedge clk_i); #1;
    wb_adr_i = 32'h104;
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_ack: got %b expected 1", wb_ack_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rstmid_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_stall: got %b expected 0", wb_stall_o); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL rstmid_dat: got %h expected 0", wb_dat_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rstmid_stale_ack: got %b expected 0", wb_ack_o); end
    wb_cyc_i = 1'b0;
    bus_xfer(1'b0, 32'h100, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h600DF00D) begin failures++; $display("FAIL rstmid_retained: got %h expected 600df00d", r); end
  endtask

  initial begin
    test_reset();
    @(posedge clk_i); #1;
    test_single();
    test_byte_enables();
    test_out_of_range();
    test_burst();
    test_read_after_write();
    test_abort();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
